// File: rtl/alu_issue_ctrl.sv
// Register-addressed command front-end for the combinational ALU; 3-state issue/capture/respond FSM.
// Build option: define ALU_ISSUE_OFCNT_EN to enable the saturating overflow counter on of_cnt.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_NUM    = 4,
  localparam int AW        = $clog2(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [AW-1:0]         cmd_rd,
  input  logic [AW-1:0]         cmd_ra,
  input  logic [AW-1:0]         cmd_rb,
  input  logic                  host_we,
  input  logic [AW-1:0]         host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] alu_dina,
  output logic [DATA_WIDTH-1:0] alu_dinb,
  output logic [3:0]            alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_doutr,
  input  logic                  alu_doutz,
  input  logic                  alu_flag_of,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_zero,
  output logic                  rsp_of,
  output logic [7:0]            of_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state;
  logic [AW-1:0]         rd_q;
  logic [DATA_WIDTH-1:0] regs [REG_NUM];

  // Gated by rst_n so nothing is accepted while reset is held.
  assign cmd_ready = rst_n && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_q       <= '0;
      alu_dina   <= '0;
      alu_dinb   <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_of     <= 1'b0;
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Operands are sampled from the pre-write file, so a same-edge preload is not forwarded.
          if (host_we) regs[host_addr] <= host_wdata;
          if (cmd_valid) begin
            alu_dina   <= regs[cmd_ra];
            alu_dinb   <= regs[cmd_rb];
            alu_opcode <= cmd_op;
            rd_q       <= cmd_rd;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data    <= alu_doutr;
          rsp_zero    <= alu_doutz;
          rsp_of      <= alu_flag_of;
          regs[rd_q]  <= alu_doutr;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_OFCNT_EN
  logic [7:0] of_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      of_cnt_q <= 8'h00;
    end else if (state == EXEC && alu_flag_of && of_cnt_q != 8'hFF) begin
      of_cnt_q <= of_cnt_q + 8'h01;
    end
  end

  assign of_cnt = of_cnt_q;
`else
  assign of_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed plus randomized bench for alu_issue_ctrl with a stub ALU and a register-file reference model.
module tb_alu_issue_ctrl;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam logic [3:0] ALUC_ADD = 4'd0;
  localparam logic [3:0] ALUC_SUB = 4'd1;
  localparam logic [3:0] ALUC_AND = 4'd2;
  localparam logic [3:0] ALUC_OR  = 4'd3;
  localparam logic [3:0] ALUC_XOR = 4'd4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic [AW-1:0] cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic [DW-1:0] alu_dina, alu_dinb, alu_doutr;
  logic [3:0]    alu_opcode;
  logic          alu_doutz, alu_flag_of;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero, rsp_of;
  logic [7:0]    of_cnt;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] mregs [4];
  int ocnt = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_WIDTH(DW), .REG_NUM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .alu_dina(alu_dina), .alu_dinb(alu_dinb), .alu_opcode(alu_opcode),
    .alu_doutr(alu_doutr), .alu_doutz(alu_doutz), .alu_flag_of(alu_flag_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_of(rsp_of), .of_cnt(of_cnt)
  );

  // {carry/borrow, result} of the stub ALU
  function automatic logic [DW:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      ALUC_ADD: alu_f = {1'b0, a} + {1'b0, b};
      ALUC_SUB: alu_f = {1'b0, a} - {1'b0, b};
      ALUC_AND: alu_f = {1'b0, a & b};
      ALUC_OR:  alu_f = {1'b0, a | b};
      ALUC_XOR: alu_f = {1'b0, a ^ b};
      default:  alu_f = {1'b0, a};
    endcase
  endfunction

  always_comb begin
    {alu_flag_of, alu_doutr} = alu_f(alu_opcode, alu_dina, alu_dinb);
    alu_doutz = (alu_doutr == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) mregs[i] = '0;
    ocnt = 0;
  endtask

  function automatic logic [7:0] exp_ocnt();
`ifdef ALU_ISSUE_OFCNT_EN
    exp_ocnt = 8'(ocnt);
`else
    exp_ocnt = 8'h00;
`endif
  endfunction

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    host_we = 1'b1; host_addr = addr; host_wdata = data;
    cycle();
    host_we = 1'b0;
    mregs[addr] = data;
  endtask

  // Issues one command; optional same-edge preload, response hold cycles, or reset during EXEC.
  task automatic issue(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rb, input int hold, input bit pw,
                       input logic [AW-1:0] paddr, input logic [DW-1:0] pdata, input bit abort);
    logic [DW-1:0] a, b, r;
    logic          of;
    a = mregs[ra];
    b = mregs[rb];
    {of, r} = alu_f(op, a, b);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    host_we = pw; host_addr = paddr; host_wdata = pdata;
    cycle();
    cmd_valid = 1'b0; host_we = 1'b0;
    if (pw) mregs[paddr] = pdata;
    check("exec_cmd_ready", cmd_ready, 0);
    check("exec_rsp_valid", rsp_valid, 0);
    check("alu_dina", alu_dina, a);
    check("alu_dinb", alu_dinb, b);
    check("alu_opcode", alu_opcode, op);
    if (abort) begin
      rst_n = 1'b0;
      cycle();
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_cmd_ready", cmd_ready, 0);
      rst_n = 1'b1;
      clear_model();
      cycle();
      check("abort_of_cnt", of_cnt, 0);
      return;
    end
    cycle();
    mregs[rd] = r;
    if (of && ocnt < 255) ocnt++;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_data, r);
    check("rsp_zero", rsp_zero, (r == '0));
    check("rsp_of", rsp_of, of);
    check("of_cnt", of_cnt, exp_ocnt());
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_op = 4'(~op); cmd_ra = ~ra;
      host_we = 1'b1; host_addr = rd; host_wdata = ~r;
      cycle();
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, r);
      check("hold_rsp_zero", rsp_zero, (r == '0));
      check("hold_rsp_of", rsp_of, of);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0; host_we = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_cmd_ready", cmd_ready, 1);
    check("opcode_held", alu_opcode, op);
  endtask

  initial begin
    clear_model();
    @(negedge clk);
    cycle();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_dina", alu_dina, 0);
    check("rst_opcode", alu_opcode, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_of_cnt", of_cnt, 0);
    rst_n = 1'b1;
    cycle();
    check("post_rst_cmd_ready", cmd_ready, 1);

    preload(2'd1, 8'h05);
    preload(2'd2, 8'h03);
    issue(ALUC_ADD, 2'd3, 2'd1, 2'd2, 0, 1'b0, 2'd0, 8'h00, 1'b0);
    issue(ALUC_SUB, 2'd0, 2'd2, 2'd2, 0, 1'b0, 2'd0, 8'h00, 1'b0);
    preload(2'd1, 8'hFF);
    preload(2'd2, 8'h01);
    issue(ALUC_ADD, 2'd3, 2'd1, 2'd2, 0, 1'b0, 2'd0, 8'h00, 1'b0);
    issue(ALUC_OR, 2'd0, 2'd3, 2'd3, 0, 1'b0, 2'd0, 8'h00, 1'b0);
    check("r0_written_zero", mregs[0], 8'h00);
    preload(2'd1, 8'h05);
    preload(2'd2, 8'h03);
    issue(ALUC_ADD, 2'd3, 2'd1, 2'd2, 0, 1'b0, 2'd0, 8'h00, 1'b0);
    issue(ALUC_ADD, 2'd0, 2'd3, 2'd3, 5, 1'b0, 2'd0, 8'h00, 1'b0);
    // same-edge preload of a source register: operand must see the old value
    issue(ALUC_XOR, 2'd2, 2'd1, 2'd0, 1, 1'b1, 2'd1, 8'hA5, 1'b0);
    issue(ALUC_ADD, 2'd1, 2'd1, 2'd1, 0, 1'b0, 2'd0, 8'h00, 1'b0);
    // reset during EXEC abandons the writeback and clears the file
    issue(ALUC_ADD, 2'd3, 2'd1, 2'd2, 0, 1'b0, 2'd0, 8'h00, 1'b1);
    issue(ALUC_OR, 2'd0, 2'd3, 2'd3, 0, 1'b0, 2'd0, 8'h00, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1)
        preload(2'($urandom), 8'($urandom));
      issue(4'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom),
            $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), 2'($urandom), 8'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
